vga_scan_gen: RTL

This block is the scan-side master of the pixel interface. It divides the system clock into a pixel enable and runs the horizontal and vertical counters. It presents `DrawX` and `DrawY` to the colour-mapping logic and takes back that logic's `Red`/`Green`/`Blue`. It then drives registered, mutually aligned VGA sync, blank and RGB outputs, plus a once-per-frame tick that paces tank and bullet motion updates.

---
 rtl/vga_scan_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vga_scan_gen.sv
// -----------------------------------------------------------------------------
// vga_scan_gen
//
// Scan-side master of the pixel interface. Divides Clk into a one-cycle pixel
// strobe, runs the horizontal/vertical raster counters, exposes the raw counts
// to the colour-mapping logic and registers sync, blank and colour so that all
// of them describe the same pixel. Also emits a one-Clk frame tick at the start
// of vertical blank.
//
// Optional feature: define VGA_FRAME_COUNT_EN to build a 16-bit frame counter
// that increments on every frame_tick. When undefined, frame_count is tied to 0.
//
// Ports:
//   Clk          in   system clock (single domain)
//   Reset        in   synchronous, active-high reset
//   pix_en       out  one-Clk pixel strobe (0 while Reset is high)
//   DrawX        out  [9:0] current horizontal count, 0..H_TOTAL-1
//   DrawY        out  [9:0] current vertical count, 0..V_TOTAL-1
//   Red/Green/Blue in [7:0] colour for (DrawX, DrawY) from the mapper
//   VGA_HS       out  horizontal sync, active low
//   VGA_VS       out  vertical sync, active low
//   VGA_BLANK_N  out  high while a visible pixel is on the outputs
//   VGA_R/G/B    out  [7:0] registered pixel colour (0 outside visible area)
//   frame_tick   out  one-Clk pulse following the load of (0, V_VISIBLE)
//   frame_count  out  [15:0] frame counter (0 unless VGA_FRAME_COUNT_EN)
// -----------------------------------------------------------------------------
module vga_scan_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        pix_en,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    input  logic [7:0]  Red,
    input  logic [7:0]  Green,
    input  logic [7:0]  Blue,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Colour is forced to black outside the visible window so the DAC never
    // sees mapper output during blanking.
    function automatic logic [7:0] gate_colour(input logic [7:0] c, input logic en);
        return en ? c : 8'd0;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_wrap;
    logic             visible_p0;
    logic             hs_n_p0;
    logic             vs_n_p0;
    logic             tick_load_p0;

    // ---- stage p0: clock divider, raster counters, decode of current counts
    assign pix_en = ~Reset & (div_cnt == DIV_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign h_wrap = (h_cnt == H_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap) begin
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    assign DrawX = h_cnt;
    assign DrawY = v_cnt;

    assign visible_p0   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_n_p0      = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_n_p0      = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    // True on the edge whose counter update loads (0, V_VISIBLE).
    assign tick_load_p0 = h_wrap && (v_cnt == V_VIS_LAST);

    // ---- stage p1: registered outputs, one pixel behind the counters
    always_ff @(posedge Clk) begin
        if (Reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'd0;
            VGA_G       <= 8'd0;
            VGA_B       <= 8'd0;
        end else if (pix_en) begin
            VGA_HS      <= hs_n_p0;
            VGA_VS      <= vs_n_p0;
            VGA_BLANK_N <= visible_p0;
            VGA_R       <= gate_colour(Red,   visible_p0);
            VGA_G       <= gate_colour(Green, visible_p0);
            VGA_B       <= gate_colour(Blue,  visible_p0);
        end
    end

    // Single-Clk pulse regardless of CLK_DIV: cleared on every non-load edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_en && tick_load_p0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt_q <= 16'd0;
        end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 16'd0;
`endif

endmodule
